// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported, variable-latency memory between the fetch
// and data ports. The data port always wins, and a watchdog bounds each access.
module unified_mem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 255,
  parameter int CW       = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_done,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          timeout_err,
  output logic [CW-1:0] if_wait_cnt,
  output logic [CW-1:0] dm_wait_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I, RESP} state_t;

  localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  state_t        state, state_d;
  logic [WW-1:0] wait_cnt, wait_d;
  logic          mem_req_d, mem_we_d, if_done_d, dm_done_d, timeout_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d, if_rdata_d, dm_rdata_d;
  logic [DW-1:0] resp_data;

  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

  // Ack wins over expiry on the same cycle; a store never returns data.
  assign resp_data = (mem_ack && !mem_we) ? mem_rdata : '0;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state;
    wait_d      = wait_cnt;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    if_rdata_d  = if_rdata;
    dm_rdata_d  = dm_rdata;
    timeout_d   = timeout_err;

    unique case (state)
      IDLE: begin
        if (dm_req) begin
          state_d     = BUSY_D;
          wait_d      = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
        end else if (if_req) begin
          state_d     = BUSY_I;
          wait_d      = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
        end
      end
      BUSY_D, BUSY_I: begin
        if (mem_ack || wait_cnt == WAIT_LAST) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (!mem_ack) timeout_d = 1'b1;
          if (state == BUSY_D) begin
            dm_done_d  = 1'b1;
            dm_rdata_d = resp_data;
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = resp_data;
          end
        end else begin
          wait_d = wait_cnt + WW'(1);
        end
      end
      // No arbitration here, so a requester still showing its old req is not re-served.
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_done     <= 1'b0;
      dm_done     <= 1'b0;
      if_rdata    <= '0;
      dm_rdata    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      wait_cnt    <= wait_d;
      mem_req     <= mem_req_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      if_done     <= if_done_d;
      dm_done     <= dm_done_d;
      if_rdata    <= if_rdata_d;
      dm_rdata    <= dm_rdata_d;
      timeout_err <= timeout_d;
    end
  end

  // Stall-cycle counters saturate at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_wait_cnt <= '0;
      dm_wait_cnt <= '0;
    end else begin
      if (if_stall && !(&if_wait_cnt)) if_wait_cnt <= if_wait_cnt + CW'(1);
      if (dm_stall && !(&dm_wait_cnt)) dm_wait_cnt <= dm_wait_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: cycle-exact timing of fetch, data,
// contention, store, timeout, reset and withdrawn-request scenarios.
module tb_unified_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_done, if_stall;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_done, dm_stall;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          timeout_err;
  logic [CW-1:0] if_wait_cnt, dm_wait_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses;

  unified_mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .timeout_err(timeout_err), .if_wait_cnt(if_wait_cnt), .dm_wait_cnt(dm_wait_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one cycle; inputs driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_mem_req",  64'(mem_req), 64'd0);
    check("rst_mem_we",   64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_done",     64'({if_done, dm_done}), 64'd0);
    check("rst_timeout",  64'(timeout_err), 64'd0);
    check("rst_cnts",     64'({if_wait_cnt, dm_wait_cnt}), 64'd0);
    check("rst_rdata",    64'({if_rdata, dm_rdata}), 64'd0);

    // Stray ack while idle is ignored.
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_ack = 1'b0;
    check("stray_ack_req",  64'(mem_req), 64'd0);
    check("stray_ack_done", 64'({if_done, dm_done}), 64'd0);

    // Single fetch: request at t, ack at t+1, done at t+2.
    if_req = 1'b1; if_addr = 32'h40;
    step();                                            // t+1
    check("fetch_req",  64'(mem_req), 64'd1);
    check("fetch_addr", 64'(mem_addr), 64'h40);
    check("fetch_we",   64'(mem_we), 64'd0);
    check("fetch_stall", 64'(if_stall), 64'd1);
    mem_ack = 1'b1; mem_rdata = 32'h8C01_0004;
    step();                                            // t+2
    check("fetch_done",  64'(if_done), 64'd1);
    check("fetch_rdata", 64'(if_rdata), 64'h8C01_0004);
    check("fetch_nostall", 64'(if_stall), 64'd0);
    check("fetch_mem_req_drop", 64'(mem_req), 64'd0);
    mem_ack = 1'b0; if_req = 1'b0;
    step();                                            // t+3
    check("fetch_done_1cyc", 64'(if_done), 64'd0);
    check("fetch_wait_cnt",  64'(if_wait_cnt), 64'd2);

    // Store without reset; the preceding fetch left nonzero if_rdata.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
    step();                                            // t+1
    check("store_we",    64'(mem_we), 64'd1);
    check("store_addr",  64'(mem_addr), 64'h200);
    check("store_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    step();                                            // t+2
    check("store_hold_req",   64'(mem_req), 64'd1);
    check("store_hold_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    step();                                            // t+3
    check("store_done",  64'(dm_done), 64'd1);
    check("store_rdata", 64'(dm_rdata), 64'd0);
    mem_ack = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    step();

    // Timeout: no ack ever, mem_req high for exactly MAX_WAIT cycles.
    if_req = 1'b1; if_addr = 32'h300;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (mem_req) pulses++;
    end                                                // now at t+5
    check("to_req_cycles", 64'(pulses), 64'd4);
    check("to_mem_req",    64'(mem_req), 64'd0);
    check("to_done",       64'(if_done), 64'd1);
    check("to_rdata",      64'(if_rdata), 64'd0);
    check("to_err",        64'(timeout_err), 64'd1);
    if_req = 1'b0;
    step();
    step();
    check("to_err_sticky", 64'(timeout_err), 64'd1);
    do_reset();
    check("to_err_cleared", 64'(timeout_err), 64'd0);

    // Ack on the expiry cycle counts as success.
    if_req = 1'b1; if_addr = 32'h700;
    step(); step(); step(); step();                    // t+4: fourth BUSY cycle
    mem_ack = 1'b1; mem_rdata = 32'h5A5A_5A5A;
    step();                                            // t+5
    check("edge_done",  64'(if_done), 64'd1);
    check("edge_rdata", 64'(if_rdata), 64'h5A5A_5A5A);
    check("edge_no_err", 64'(timeout_err), 64'd0);
    mem_ack = 1'b0; if_req = 1'b0;
    do_reset();

    // Contention: data first, fetch after data's RESP; ack on third BUSY cycle.
    if_req = 1'b1; if_addr = 32'h80;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    step();                                            // t+1
    check("cont_d_first", 64'(mem_addr), 64'h100);
    check("cont_d_req",   64'(mem_req), 64'd1);
    step();                                            // t+2
    step();                                            // t+3
    mem_ack = 1'b1; mem_rdata = 32'h0000_1111;
    step();                                            // t+4
    check("cont_dm_done",  64'(dm_done), 64'd1);
    check("cont_dm_rdata", 64'(dm_rdata), 64'h1111);
    check("cont_if_not_done", 64'(if_done), 64'd0);
    mem_ack = 1'b0; dm_req = 1'b0;
    step();                                            // t+5 (IDLE)
    check("cont_idle_gap", 64'(mem_req), 64'd0);
    step();                                            // t+6
    check("cont_i_req",  64'(mem_req), 64'd1);
    check("cont_i_addr", 64'(mem_addr), 64'h80);
    check("cont_dm_cnt", 64'(dm_wait_cnt), 64'd4);
    step();                                            // t+7
    step();                                            // t+8
    mem_ack = 1'b1; mem_rdata = 32'h0000_2222;
    step();                                            // t+9
    check("cont_if_done",  64'(if_done), 64'd1);
    check("cont_if_rdata", 64'(if_rdata), 64'h2222);
    check("cont_if_cnt_sat", 64'(if_wait_cnt), 64'd7);
    mem_ack = 1'b0; if_req = 1'b0;

    // Reset on the second cycle of BUSY_D aborts without a done pulse.
    do_reset();
    dm_req = 1'b1; dm_addr = 32'h400;
    step();                                            // BUSY_D cycle 1
    step();                                            // BUSY_D cycle 2
    reset = 1'b1; dm_req = 1'b0;
    step();
    check("rmid_mem_req", 64'(mem_req), 64'd0);
    check("rmid_no_done", 64'(dm_done), 64'd0);
    check("rmid_cnts",    64'({if_wait_cnt, dm_wait_cnt}), 64'd0);
    reset = 1'b0;
    if_req = 1'b1; if_addr = 32'h500;
    step();
    check("rmid_new_req",  64'(mem_req), 64'd1);
    check("rmid_new_addr", 64'(mem_addr), 64'h500);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
    step();
    check("rmid_new_done", 64'(if_done), 64'd1);
    check("rmid_new_rdata", 64'(if_rdata), 64'hCAFE_0001);
    mem_ack = 1'b0; if_req = 1'b0;
    step();

    // Withdrawn request still completes with a single done, no re-grant.
    if_req = 1'b1; if_addr = 32'h600;
    step();                                            // t+1: granted
    check("wd_grant", 64'(mem_req), 64'd1);
    if_req = 1'b0;
    step();                                            // t+2
    check("wd_still_busy", 64'(mem_req), 64'd1);
    mem_ack = 1'b1; mem_rdata = 32'h0000_ABCD;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 0) mem_ack = 1'b0;
      if (if_done) pulses++;
      if (i == 0) check("wd_rdata", 64'(if_rdata), 64'hABCD);
      if (i > 0)  check($sformatf("wd_no_regrant%0d", i), 64'(mem_req), 64'd0);
    end
    check("wd_one_pulse", 64'(pulses), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Sequential arbiter sharing one single-ported, variable-latency unified memory between the pipeline's instruction-fetch port (IF stage) and data port (MEM stage). Each requester holds a request until a one-cycle `*_done` pulse. The arbiter serialises the requests, always favouring the data port because it belongs to the older instruction. It provides stall signals for the PC / IF-ID write enables, a wait-timeout watchdog, and saturating wait-cycle performance counters.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `MAX_WAIT`, 255, cycles a granted access may wait for `mem_ack` before timeout (≥1)
- `CW`, 32, performance counter width
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-high
- `if_req`  in  1  fetch request, held until `if_done`
- `if_addr`  in  AW  fetch address, stable while `if_req`
- `if_done`  out  1  one-cycle completion pulse to fetch
- `if_rdata`  out  DW  fetched word, valid when `if_done`
- `if_stall`  out  1  `if_req & ~if_done`
- `dm_req`  in  1  data request, held until `dm_done`
- `dm_we`  in  1  1 = store, 0 = load
- `dm_addr`  in  AW  data address
- `dm_wdata`  in  DW  store data
- `dm_done`  out  1  one-cycle completion pulse to data port
- `dm_rdata`  out  DW  load data, valid when `dm_done`; 0 for stores
- `dm_stall`  out  1  `dm_req & ~dm_done`
- `mem_req`  out  1  memory access request, held until `mem_ack`
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_ack`  in  1  memory completion; `mem_rdata` valid the same cycle
- `mem_rdata`  in  DW  memory read data
- `timeout_err`  out  1  sticky; set on watchdog expiry
- `if_wait_cnt`  out  CW  cycles with `if_stall`=1, saturating
- `dm_wait_cnt`  out  CW  cycles with `dm_stall`=1, saturating

## Operation
- FSM states: IDLE, BUSY_D, BUSY_I, RESP. All mem_* and *_done / *_rdata outputs are registered.
- IDLE:
  - `dm_req` → BUSY_D. Otherwise `if_req` → BUSY_I. Otherwise stay in IDLE.
  - On the grant edge, latch `mem_addr`/`mem_we`/`mem_wdata` from the granted port. The fetch port is granted with `mem_we`=0 and `mem_wdata`=0.
- BUSY_x:
  - `mem_req`=1 and the latched fields are held stable. The wait counter increments each cycle.
  - On `mem_ack`, capture `mem_rdata` into `x_rdata` (0 if store) and go to RESP with `x_done`=1.
  - If the wait counter reaches `MAX_WAIT` without `mem_ack`: set `timeout_err`, set `x_rdata`=0, go to RESP with `x_done`=1, and drop `mem_req`.
- RESP: `x_done`=1 for exactly this cycle. No arbitration happens here, so a requester still sampling its old `req` is never re-served. Next state is IDLE.
- A request withdrawn after its grant still completes. The `done` pulse is issued and ignored by the requester.
- Requests are not queued. A request must still be asserted in IDLE to win arbitration.
- Wait counters increment every cycle their stall is 1 and hold at all-ones.
- `timeout_err` clears only on `reset`.

## Timing
- Reset values: state IDLE; `mem_req`, `mem_we`, `if_done`, `dm_done`, `timeout_err` = 0; `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata`, both counters = 0.
- Request seen in IDLE at cycle t:
  - `mem_req`=1 from t+1.
  - If `mem_ack` arrives at cycle t+k (k≥1), `done` occurs at t+k+1.
  - IDLE at t+k+2.
  - Minimum request-to-done latency is 2 cycles. Minimum back-to-back spacing is 3 cycles per access.
- Simultaneous `if_req` and `dm_req` in IDLE: data is served first. Fetch is granted at the IDLE following data's RESP, provided `if_req` is still high.
- `mem_ack` while `mem_req`=0 is ignored.
- A `mem_ack` landing on the same cycle the watchdog expires counts as success: real data is returned and `timeout_err` is not set.
- `reset` in any state: returns to IDLE next edge, `mem_req` drops immediately on that edge, and no `done` pulse is issued for the aborted access.
- Stall outputs are combinational from the inputs and `done`. No other combinational input-to-output paths exist.

## Test plan
- Single fetch:
  - Stimulus: `if_req`=1, `if_addr`=0x40; memory acks 1 cycle after `mem_req` with 0x8C010004.
  - Required: `mem_addr`=0x40 and `mem_we`=0; `if_done` at t+2 with `if_rdata`=0x8C010004; `if_wait_cnt`=2.
- Contention:
  - Stimulus: `if_req` and `dm_req` (load, 0x100) both rise at t; memory acks after 3 cycles.
  - Required: data access issues first; `dm_done` at t+4; fetch `mem_req` at t+6; `if_done` at t+9.
- Store:
  - Stimulus: `dm_we`=1, `dm_addr`=0x200, `dm_wdata`=0xDEADBEEF.
  - Required: `mem_we`=1 and `mem_wdata`=0xDEADBEEF held until ack; `dm_rdata`=0 on `dm_done`.
- Timeout:
  - Stimulus: `MAX_WAIT`=4; memory never acks.
  - Required: `mem_req` high for exactly 4 cycles; `done` with `rdata`=0; `timeout_err`=1 persists until `reset`.
- Reset mid-access:
  - Stimulus: assert `reset` on the second cycle of BUSY_D.
  - Required: next cycle shows IDLE, `mem_req`=0, no `dm_done`, counters at 0; a new `if_req` is then served normally.
- Withdrawn request:
  - Stimulus: drop `if_req` one cycle after grant.
  - Required: access still completes; one `if_done` pulse; arbiter returns to IDLE with no re-grant.
